// File: rtl/pq_lockstep_tx_pkg.sv
// Shared types and helpers for the p/q lockstep serial transmitter.
package pq_lockstep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int frame_len(input int data_w, input int stop_bits);
    return 2 + data_w + stop_bits;
  endfunction

endpackage

// File: rtl/pq_bit_counter.sv
// Loadable down-counter with terminal-count flag; times the DATA and STOP phases.
module pq_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/pq_lockstep_tx.sv
// Framed serial transmitter driving identical p/q lanes (START, DATA LSB-first, PARITY, STOP).
// Optional q-lane fault injection when PQ_LOCKSTEP_TX_FAULT_INJECT_EN is defined.
module pq_lockstep_tx
  import pq_lockstep_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              p,
  output logic              q,
  output logic              busy,
  output logic              frame_done
`ifdef PQ_LOCKSTEP_TX_FAULT_INJECT_EN
  ,
  input  logic              fault_req,
  input  logic [((DATA_W > 1) ? $clog2(DATA_W) : 1)-1:0] fault_bit
`endif
);

  localparam int DW_CW = $clog2(DATA_W + 1);
  localparam int SB_CW = $clog2(STOP_BITS + 1);
  localparam int CNT_W = (DW_CW > SB_CW) ? DW_CW : SB_CW;
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS - 1);

  state_t state, state_next;
  logic hs;
  logic cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt, cnt_load_val;
  logic [DATA_W-1:0] sh, sh_next, flip, flip_next;
  logic par;
  logic last_stop_next;
  logic p_next, q_next, busy_next, ready_next;

  assign hs = in_valid & in_ready;

  pq_bit_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_load     = 1'b0;
    cnt_load_val = DATA_LOAD;
    cnt_en       = 1'b0;
    unique case (state)
      IDLE:   if (hs) state_next = START;
      START:  begin
        state_next   = DATA;
        cnt_load     = 1'b1;
        cnt_load_val = DATA_LOAD;
      end
      DATA:   if (cnt_tc) state_next = PARITY; else cnt_en = 1'b1;
      PARITY: begin
        state_next   = STOP;
        cnt_load     = 1'b1;
        cnt_load_val = STOP_LOAD;
      end
      STOP:   if (cnt_tc) state_next = hs ? START : IDLE; else cnt_en = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  // Word and fault mask are captured together so a frame in flight is immune to later fault_req changes.
  always_comb begin
    sh_next   = sh;
    flip_next = flip;
    if (state == DATA) begin
      sh_next   = sh >> 1;
      flip_next = flip >> 1;
    end else if (hs) begin
      sh_next = in_data;
`ifdef PQ_LOCKSTEP_TX_FAULT_INJECT_EN
      flip_next = fault_req ? (DATA_W'(1) << fault_bit) : '0;
`else
      flip_next = '0;
`endif
    end
  end

  // NOTE: datapath registers carry no reset; the state machine never reads them before a handshake loads them.
  always_ff @(posedge clk) begin
    sh   <= sh_next;
    flip <= flip_next;
    if (hs) par <= (^in_data) ^ 1'(PARITY_ODD);
  end

  // Outputs are computed from the next state and registered, so the start bit appears the cycle after the handshake.
  always_comb begin
    last_stop_next = (state_next == STOP) &&
                     ((state == PARITY) ? (STOP_BITS == 1) : (cnt == CNT_W'(1)));
    p_next = IDLE_LEVEL;
    q_next = IDLE_LEVEL;
    unique case (state_next)
      START:  begin p_next = 1'b0; q_next = 1'b0; end
      DATA:   begin p_next = sh_next[0]; q_next = sh_next[0] ^ flip_next[0]; end
      PARITY: begin p_next = par; q_next = par; end
      default: begin p_next = IDLE_LEVEL; q_next = IDLE_LEVEL; end
    endcase
    busy_next  = (state_next != IDLE);
    ready_next = (state_next == IDLE) || last_stop_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p          <= IDLE_LEVEL;
      q          <= IDLE_LEVEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      p          <= p_next;
      q          <= q_next;
      busy       <= busy_next;
      frame_done <= last_stop_next;
      in_ready   <= ready_next;
    end
  end

endmodule
